// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that merges NREQ writeback sources onto the two regfile write ports.
// Optional stall counter enabled by defining WB_ARB_STALL_CNT_EN; otherwise stall_count reads 0.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              we_1,
  output logic [AW-1:0]     writeaddr_1,
  output logic [DW-1:0]     writedata_1,
  output logic              we_2,
  output logic [AW-1:0]     writeaddr_2,
  output logic [DW-1:0]     writedata_2,
  output logic [31:0]       stall_count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [AW-1:0] addr_a [NREQ];
  logic [DW-1:0] data_a [NREQ];
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] g1_idx, g2_idx, idx, last_idx, rr_next;
  logic          g1_found, g2_found;
  logic [PW:0]   sum;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_a[i] = req_addr[i*AW +: AW];
      data_a[i] = req_data[i*DW +: DW];
    end
  end

  // Scan in rotating order from rr_ptr; a same-address follower of G1 is skipped,
  // but addr-0 writes never conflict because they are dropped anyway.
  always_comb begin
    g1_found = 1'b0;
    g2_found = 1'b0;
    g1_idx   = '0;
    g2_idx   = '0;
    sum      = '0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ))
        sum = sum - (PW+1)'(NREQ);
      idx = sum[PW-1:0];
      if (!rst && req_valid[idx]) begin
        if (!g1_found) begin
          g1_found = 1'b1;
          g1_idx   = idx;
        end else if (!g2_found &&
                     ((addr_a[idx] != addr_a[g1_idx]) || (addr_a[idx] == '0))) begin
          g2_found = 1'b1;
          g2_idx   = idx;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (g1_found) req_ready[g1_idx] = 1'b1;
    if (g2_found) req_ready[g2_idx] = 1'b1;
  end

  always_comb begin
    last_idx = g2_found ? g2_idx : g1_idx;
    rr_next  = (last_idx == PW'(NREQ-1)) ? '0 : last_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_1        <= 1'b0;
      writeaddr_1 <= '0;
      writedata_1 <= '0;
      we_2        <= 1'b0;
      writeaddr_2 <= '0;
      writedata_2 <= '0;
      rr_ptr      <= '0;
    end else begin
      we_1 <= g1_found && (addr_a[g1_idx] != '0);
      we_2 <= g2_found && (addr_a[g2_idx] != '0);
      if (g1_found) begin
        writeaddr_1 <= addr_a[g1_idx];
        writedata_1 <= data_a[g1_idx];
      end
      if (g2_found) begin
        writeaddr_2 <= addr_a[g2_idx];
        writedata_2 <= data_a[g2_idx];
      end
      if (g1_found)
        rr_ptr <= rr_next;
    end
  end

`ifdef WB_ARB_STALL_CNT_EN
  logic        stall_now;
  logic [31:0] stall_q;

  assign stall_now = |(req_valid & ~req_ready);

  always_ff @(posedge clk) begin
    if (rst)
      stall_q <= '0;
    else if (stall_now)
      stall_q <= stall_q + 32'd1;
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule
